// File: rtl/control_unit_if.sv
// Instruction-decode type shared by the control unit and datapath, plus the
// control bus between them (control unit is master, datapath is slave).
package control_unit_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_HALT
    } decoded_instruction_type;

endpackage

interface control_unit_if;
    import control_unit_pkg::*;

    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;

    modport master (
        input  decoded_instruction, zero_op, neg_op,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, ram_write_enable, halt
    );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle Moore FSM sequencing fetch/decode/execute for the K&S 16-bit
// processor; all control outputs are decoded from registered state.
module control_unit #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    control_unit_if.master bus
);
    import control_unit_pkg::*;

    typedef enum logic [3:0] {
        S_FETCH,
        S_FETCH_LATCH,
        S_DECODE,
        S_LOAD_WAIT,
        S_LOAD_WR,
        S_STORE,
        S_ALU,
        S_BRANCH_TAKE,
        S_HALTED
    } state_t;

    // With a combinational RAM the wait states are skipped entirely.
    localparam logic [2:0] LAST_WAIT   = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
    localparam state_t     FETCH_ENTRY = (WAIT_CYCLES == 0) ? S_FETCH_LATCH : S_FETCH;
    localparam state_t     LOAD_ENTRY  = (WAIT_CYCLES == 0) ? S_LOAD_WR : S_LOAD_WAIT;

    state_t                  state;
    state_t                  next_state;
    logic [2:0]              wait_cnt;
    decoded_instruction_type alu_instr;

    logic       branch_d;
    logic       pc_enable_d;
    logic       ir_enable_d;
    logic       addr_sel_d;
    logic       c_sel_d;
    logic [1:0] operation_d;
    logic       write_reg_enable_d;
    logic       flags_reg_enable_d;
    logic       ram_write_enable_d;
    logic       halt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            alu_instr <= I_NOP;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                alu_instr <= bus.decoded_instruction;
        end
    end

    // Counter restarts whenever a wait state is freshly entered.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= 3'd0;
        else if ((next_state == S_FETCH && state != S_FETCH) ||
                 (next_state == S_LOAD_WAIT && state != S_LOAD_WAIT))
            wait_cnt <= 3'd0;
        else if (state == S_FETCH || state == S_LOAD_WAIT)
            wait_cnt <= wait_cnt + 3'd1;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:
                if (WAIT_CYCLES == 0 || wait_cnt == LAST_WAIT)
                    next_state = S_FETCH_LATCH;
            S_FETCH_LATCH:
                next_state = S_DECODE;
            S_DECODE: begin
                next_state = FETCH_ENTRY;
                case (bus.decoded_instruction)
                    I_LOAD:   next_state = LOAD_ENTRY;
                    I_STORE:  next_state = S_STORE;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                              next_state = S_ALU;
                    I_BRANCH: next_state = S_BRANCH_TAKE;
                    I_BZERO:  if (bus.zero_op)  next_state = S_BRANCH_TAKE;
                    I_BNZERO: if (!bus.zero_op) next_state = S_BRANCH_TAKE;
                    I_BNEG:   if (bus.neg_op)   next_state = S_BRANCH_TAKE;
                    I_BNNEG:  if (!bus.neg_op)  next_state = S_BRANCH_TAKE;
                    I_HALT:   next_state = S_HALTED;
                    default:  next_state = FETCH_ENTRY;
                endcase
            end
            S_LOAD_WAIT:
                if (wait_cnt == LAST_WAIT)
                    next_state = S_LOAD_WR;
            S_LOAD_WR:     next_state = FETCH_ENTRY;
            S_STORE:       next_state = FETCH_ENTRY;
            S_ALU:         next_state = FETCH_ENTRY;
            S_BRANCH_TAKE: next_state = FETCH_ENTRY;
            S_HALTED:      next_state = S_HALTED;
            default:       next_state = S_FETCH;
        endcase
    end

    always_comb begin
        branch_d           = 1'b0;
        pc_enable_d        = 1'b0;
        ir_enable_d        = 1'b0;
        addr_sel_d         = 1'b0;
        c_sel_d            = 1'b0;
        operation_d        = 2'b00;
        write_reg_enable_d = 1'b0;
        flags_reg_enable_d = 1'b0;
        ram_write_enable_d = 1'b0;
        halt_d             = 1'b0;
        unique case (state)
            S_FETCH_LATCH: begin
                ir_enable_d = 1'b1;
                pc_enable_d = 1'b1;
            end
            S_LOAD_WAIT:
                addr_sel_d = 1'b1;
            S_LOAD_WR: begin
                addr_sel_d         = 1'b1;
                c_sel_d            = 1'b1;
                write_reg_enable_d = 1'b1;
            end
            S_STORE: begin
                addr_sel_d         = 1'b1;
                ram_write_enable_d = 1'b1;
            end
            // MOVE rides the OR path (A|A) and leaves the flags untouched.
            S_ALU: begin
                write_reg_enable_d = 1'b1;
                case (alu_instr)
                    I_ADD: begin operation_d = 2'b01; flags_reg_enable_d = 1'b1; end
                    I_SUB: begin operation_d = 2'b10; flags_reg_enable_d = 1'b1; end
                    I_AND: begin operation_d = 2'b11; flags_reg_enable_d = 1'b1; end
                    I_OR:  begin operation_d = 2'b00; flags_reg_enable_d = 1'b1; end
                    default: operation_d = 2'b00;
                endcase
            end
            S_BRANCH_TAKE: begin
                branch_d    = 1'b1;
                pc_enable_d = 1'b1;
            end
            S_HALTED:
                halt_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.branch           = branch_d;
    assign bus.pc_enable        = pc_enable_d;
    assign bus.ir_enable        = ir_enable_d;
    assign bus.addr_sel         = addr_sel_d;
    assign bus.c_sel            = c_sel_d;
    assign bus.operation        = operation_d;
    assign bus.write_reg_enable = write_reg_enable_d;
    assign bus.flags_reg_enable = flags_reg_enable_d;
    assign bus.ram_write_enable = ram_write_enable_d;
    assign bus.halt             = halt_d;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: two instances (1 and 2 RAM wait cycles),
// expected per-cycle output words queued from the instruction timing table.
module tb_control_unit;
    import control_unit_pkg::*;

    // Output word layout: branch pc ir addr csel op[1:0] wre fre rwe halt
    localparam logic [10:0] W_IDLE  = 11'b0;
    localparam logic [10:0] W_LATCH = 11'b011_0000_0000;
    localparam logic [10:0] W_ADDR  = 11'b000_1000_0000;
    localparam logic [10:0] W_LDWR  = 11'b000_1100_1000;
    localparam logic [10:0] W_STORE = 11'b000_1000_0010;
    localparam logic [10:0] W_BR    = 11'b110_0000_0000;
    localparam logic [10:0] W_HALT  = 11'b000_0000_0001;
    localparam logic [10:0] W_WRITE = 11'b000_0000_1000;
    localparam logic [10:0] W_FLAGS = 11'b000_0000_0100;

    logic clk;
    logic rst_a;
    logic rst_b;

    logic [10:0] obs_a;
    logic [10:0] obs_b;
    logic [10:0] expected_q[$];

    int checks;
    int failures;

    control_unit_if bus_a();
    control_unit_if bus_b();

    control_unit #(.WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    control_unit #(.WAIT_CYCLES(2)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    assign obs_a = {bus_a.branch, bus_a.pc_enable, bus_a.ir_enable, bus_a.addr_sel,
                    bus_a.c_sel, bus_a.operation, bus_a.write_reg_enable,
                    bus_a.flags_reg_enable, bus_a.ram_write_enable, bus_a.halt};
    assign obs_b = {bus_b.branch, bus_b.pc_enable, bus_b.ir_enable, bus_b.addr_sel,
                    bus_b.c_sel, bus_b.operation, bus_b.write_reg_enable,
                    bus_b.flags_reg_enable, bus_b.ram_write_enable, bus_b.halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [10:0] observed(input int sel);
        return (sel == 0) ? obs_a : obs_b;
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] actual,
                               input logic [10:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, actual, expected);
        end
    endtask

    task automatic driveInputs(input int sel, input decoded_instruction_type ins,
                               input logic z, input logic n);
        if (sel == 0) begin
            bus_a.decoded_instruction = ins;
            bus_a.zero_op = z;
            bus_a.neg_op  = n;
        end else begin
            bus_b.decoded_instruction = ins;
            bus_b.zero_op = z;
            bus_b.neg_op  = n;
        end
    endtask

    // Compare the current cycle against the queue head, then advance a cycle.
    task automatic runChecks(input int sel, input string tag);
        logic [10:0] exp_word;
        while (expected_q.size() > 0) begin
            exp_word = expected_q.pop_front();
            checkOutput(tag, observed(sel), exp_word);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushFetch(input int waits);
        for (int i = 0; i < waits; i++) expected_q.push_back(W_IDLE);
        expected_q.push_back(W_LATCH);
        expected_q.push_back(W_IDLE);
    endtask

    task automatic applyStimulus(input int sel, input decoded_instruction_type ins,
                                 input logic z, input logic n, input string tag);
        int waits;
        waits = (sel == 0) ? 1 : 2;
        driveInputs(sel, ins, z, n);
        pushFetch(waits);
        case (ins)
            I_LOAD: begin
                for (int i = 0; i < waits; i++) expected_q.push_back(W_ADDR);
                expected_q.push_back(W_LDWR);
            end
            I_STORE:  expected_q.push_back(W_STORE);
            I_MOVE:   expected_q.push_back(W_WRITE);
            I_ADD:    expected_q.push_back(W_WRITE | W_FLAGS | 11'b000_0001_0000);
            I_SUB:    expected_q.push_back(W_WRITE | W_FLAGS | 11'b000_0010_0000);
            I_AND:    expected_q.push_back(W_WRITE | W_FLAGS | 11'b000_0011_0000);
            I_OR:     expected_q.push_back(W_WRITE | W_FLAGS);
            I_BRANCH: expected_q.push_back(W_BR);
            I_BZERO:  if (z)  expected_q.push_back(W_BR);
            I_BNZERO: if (!z) expected_q.push_back(W_BR);
            I_BNEG:   if (n)  expected_q.push_back(W_BR);
            I_BNNEG:  if (!n) expected_q.push_back(W_BR);
            I_HALT:   for (int i = 0; i < 25; i++) expected_q.push_back(W_HALT);
            default: ;
        endcase
        runChecks(sel, tag);
    endtask

    task automatic resetDut(input int sel, input string tag);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        @(posedge clk);
        #1;
        checkOutput(tag, observed(sel), W_IDLE);
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        driveInputs(0, I_NOP, 1'b0, 1'b0);
        driveInputs(1, I_NOP, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_a", obs_a, W_IDLE);
        checkOutput("reset_b", obs_b, W_IDLE);
        rst_a = 1'b0;
        rst_b = 1'b0;

        $display("[TB] instance A, one wait cycle");
        applyStimulus(0, I_ADD,    1'b0, 1'b0, "add");
        applyStimulus(0, I_MOVE,   1'b0, 1'b0, "move");
        applyStimulus(0, I_STORE,  1'b0, 1'b0, "store");
        applyStimulus(0, I_SUB,    1'b0, 1'b1, "sub");
        applyStimulus(0, I_AND,    1'b1, 1'b0, "and");
        applyStimulus(0, I_OR,     1'b0, 1'b0, "or");
        applyStimulus(0, I_BRANCH, 1'b0, 1'b0, "branch");
        applyStimulus(0, I_BZERO,  1'b1, 1'b0, "bzero_taken");
        applyStimulus(0, I_BZERO,  1'b0, 1'b1, "bzero_untaken");
        applyStimulus(0, I_BNZERO, 1'b0, 1'b0, "bnzero_taken");
        applyStimulus(0, I_BNZERO, 1'b1, 1'b0, "bnzero_untaken");
        applyStimulus(0, I_BNEG,   1'b0, 1'b1, "bneg_taken");
        applyStimulus(0, I_BNEG,   1'b1, 1'b0, "bneg_untaken");
        applyStimulus(0, I_BNNEG,  1'b0, 1'b1, "bnneg_untaken");
        applyStimulus(0, I_BNNEG,  1'b0, 1'b0, "bnneg_taken");
        applyStimulus(0, I_LOAD,   1'b0, 1'b0, "load_w1");
        applyStimulus(0, I_NOP,    1'b1, 1'b1, "nop");
        applyStimulus(0, decoded_instruction_type'(4'd14), 1'b1, 1'b1, "unknown");
        applyStimulus(0, I_ADD,    1'b0, 1'b0, "add_after_unknown");
        applyStimulus(0, I_HALT,   1'b0, 1'b0, "halt_a");
        resetDut(0, "reset_after_halt_a");
        applyStimulus(0, I_MOVE,   1'b0, 1'b0, "move_after_halt");

        $display("[TB] instance B, two wait cycles");
        resetDut(1, "resync_b");
        applyStimulus(1, I_LOAD,   1'b0, 1'b0, "load_w2");

        driveInputs(1, I_LOAD, 1'b0, 1'b0);
        pushFetch(2);
        runChecks(1, "load_pre_abort");
        checkOutput("load_wait", obs_b, W_ADDR);
        resetDut(1, "reset_mid_load");
        @(posedge clk);
        #1;
        checkOutput("fetch_after_abort", obs_b, W_IDLE);
        resetDut(1, "resync_after_abort");

        applyStimulus(1, I_ADD,    1'b0, 1'b0, "add_w2");
        applyStimulus(1, I_STORE,  1'b0, 1'b0, "store_w2");
        applyStimulus(1, I_BZERO,  1'b1, 1'b0, "bzero_taken_w2");
        applyStimulus(1, I_BNNEG,  1'b0, 1'b1, "bnneg_untaken_w2");
        applyStimulus(1, I_HALT,   1'b0, 1'b0, "halt_b");
        resetDut(1, "reset_after_halt_b");
        applyStimulus(1, I_NOP,    1'b0, 1'b0, "nop_w2");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
